ula_multdiv: RTL

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It is the parametrised successor to the combinational ALU control path. The main ALU keeps single-cycle ops; MULT/MULTU/DIV/DIVU/MTHI/MTLO are routed here by R-type `funct`. It runs over WIDTH cycles behind a start/busy/done handshake, and the control unit stalls on `busy`. MFHI/MFLO read `hi`/`lo` directly.

---
 rtl/ula_pkg.sv | 19 +
 rtl/ula_md_step.sv | 28 ++
 rtl/ula_multdiv.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared constants and FSM encoding for the iterative multiply/divide unit.
package ula_pkg;

   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_RUN,
      MD_FIN
   } md_state_e;

endpackage

// File: rtl/ula_md_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module ula_md_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] part_i,
   input  logic [WIDTH-1:0]   opnd_i,
   output logic [2*WIDTH-1:0] part_o,
   output logic               q_bit_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shl;
   logic [WIDTH+1:0] diff;

   always_comb begin
      sum     = {1'b0, part_i[2*WIDTH-1:WIDTH]} + (part_i[0] ? {1'b0, opnd_i} : '0);
      // partial remainder shifted left with the next dividend bit pulled in
      shl     = part_i[2*WIDTH-1:WIDTH-1];
      diff    = {1'b0, shl} - {2'b00, opnd_i};
      q_bit_o = ~diff[WIDTH+1];
      if (is_div)
         part_o = {(q_bit_o ? diff[WIDTH-1:0] : shl[WIDTH-1:0]), part_i[WIDTH-2:0], 1'b0};
      else
         part_o = {sum, part_i[WIDTH-1:1]};
   end

endmodule

// File: rtl/ula_multdiv.sv
// Iterative MULT/DIV unit with HI/LO registers; WIDTH steps plus a fix-up cycle.
// Signed MULT/DIV are enabled by defining ULA_MD_SIGNED_EN.
module ula_multdiv
   import ula_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, step_part, res;
   logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
   logic               is_div_q, is_div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d, done_q, done_d;
   logic               q_bit, is_md, op_div, is_signed, neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b;

   ula_md_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div_q),
      .part_i  (acc_q),
      .opnd_i  (opnd_q),
      .part_o  (step_part),
      .q_bit_o (q_bit)
   );

   always_comb begin
      is_md  = funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
      op_div = (funct == FN_DIV) || (funct == FN_DIVU);
`ifdef ULA_MD_SIGNED_EN
      // divide by zero keeps the raw dividend so HI returns a unchanged
      is_signed = (funct == FN_MULT) || ((funct == FN_DIV) && (b != '0));
`else
      is_signed = 1'b0;
`endif
      neg_a = is_signed & a[WIDTH-1];
      neg_b = is_signed & b[WIDTH-1];
      mag_a = neg_a ? -a : a;
      mag_b = neg_b ? -b : b;

      if (is_div_q)
         res = {(neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH]),
                (neg_q_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0])};
      else
         res = neg_q_q ? -acc_q : acc_q;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (start && is_md) begin
               state_d  = MD_RUN;
               cnt_d    = CNT_W'(WIDTH);
               acc_d    = {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
               opnd_d   = op_div ? mag_b : mag_a;
               is_div_d = op_div;
               neg_q_d  = neg_a ^ neg_b;
               neg_r_d  = neg_a;
            end else if (start && funct == FN_MTHI) begin
               hi_d = a;
            end else if (start && funct == FN_MTLO) begin
               lo_d = a;
            end
         end
         MD_RUN: begin
            acc_d = {step_part[2*WIDTH-1:1], (is_div_q ? q_bit : step_part[0])};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1))
               state_d = MD_FIN;
         end
         MD_FIN: begin
            hi_d    = res[2*WIDTH-1:WIDTH];
            lo_d    = res[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MD_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q != MD_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
